bcd2bin: RTL
============

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 Parameter NDIG, default 3, number of packed BCD input digits.
REQ-002 Parameter BINW, default 10, binary result width; SHALL satisfy 2^BINW > 10^NDIG - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 bcdHundreds  input  4  most-significant BCD digit (NDIG=3 case; generally bcd_in[4*NDIG-1:0], digit 0 = ones).
REQ-007 bcdTens  input  4  middle BCD digit.
REQ-008 bcdOnes  input  4  least-significant BCD digit.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse marking bin/err valid.
REQ-011 err  output  1  high with done when any input digit > 9.
REQ-012 bin  output  BINW  binary result; held until next accepted start.

Function
REQ-013 Conversion SHALL use reverse double-dabble: per step, shift {bcd_reg, bin_reg} right 1 bit, then subtract 3 from every 4-bit BCD field whose value is >= 8.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE + start=1 at edge N: if all digits <= 9, load bcd_reg from inputs, clear bin_reg and step counter, go to SHIFT.
REQ-016 IDLE + start=1 with any digit > 9: go directly to DONE with err=1 and bin=0; done visible after edge N+1.
REQ-017 SHIFT SHALL perform exactly BINW steps (edges N+1..N+BINW), then enter DONE with bin updated; done=1 in the cycle after edge N+BINW.
REQ-018 busy SHALL be 1 exactly while state = SHIFT.
REQ-019 DONE SHALL last one cycle, then unconditionally return to IDLE; done=1 only in DONE.
REQ-020 start while in SHIFT or DONE SHALL be ignored (no queuing, no restart).
REQ-021 Input digits SHALL be sampled only at the accepting edge; later changes SHALL not affect the result.
REQ-022 err SHALL be cleared at the next accepted start; bin and err SHALL hold their values in IDLE.
REQ-023 Step counter SHALL be ceil(log2(BINW+1)) bits wide and SHALL not wrap during a conversion.
REQ-024 Result for valid input SHALL equal 100*H + 10*T + O; max 999 -> 10'h3E7.

Reset
REQ-025 reset=1 at any edge SHALL force state IDLE, busy=0, done=0, err=0, bin=0, counter=0, bcd_reg=0.
REQ-026 reset during SHIFT SHALL abort the conversion with no done pulse.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), BCD_DIGIT_W=4, BCD_MAX=9 and ADJ_THRESH=8 constants.
REQ-029 One sub-module bcd_digit_adj (4-bit in/out: subtract 3 if >= 8) SHALL be instanced NDIG times via generate.
REQ-030 All registers in one clocked block; next-state and adjust logic combinational.

Verification
REQ-031 Start with H=9,T=9,O=9 -> busy high 10 cycles, done pulse, bin=10'd999 (3E7), err=0.
REQ-032 Start with 0,0,0 -> after 10 cycles done, bin=0, err=0.
REQ-033 Start with H=1,T=A,O=5 -> done one cycle after accept, err=1, bin=0, busy never high.
REQ-034 Start 1,2,3; re-pulse start with 4,5,6 at cycle 4 -> single done, bin=123.
REQ-035 Start 5,0,0; reset at cycle 5 -> no done, all outputs 0; next start 0,4,2 -> bin=42.
REQ-036 Exhaustive sweep 000..999 against 100H+10T+O model -> zero mismatches, each exactly 10-cycle latency.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM state encoding and the per-digit limits used by the datapath.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] ADJ_THRESH  = 4'd8;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD field.
// A field that reaches 8 or more after the right shift had a tens carry folded in, so remove 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin.sv
// Packed BCD to binary converter using reverse double-dabble, one bit per clock.
// Handshake: start is sampled only in IDLE; done pulses for one cycle when bin/err are valid.
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int BINW = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BCD_DIGIT_W-1:0] bcdHundreds,
    input  logic [BCD_DIGIT_W-1:0] bcdTens,
    input  logic [BCD_DIGIT_W-1:0] bcdOnes,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [BINW-1:0]        bin,
    output state_e                 state_dbg
);

    localparam int BCDW = BCD_DIGIT_W * NDIG;
    localparam int CNTW = $clog2(BINW + 1);
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(BINW - 1);

    logic [BCDW-1:0]      bcd_in;
    logic [BCDW-1:0]      bcd_adj;
    logic [BCDW+BINW-1:0] shifted;
    logic                 in_bad;

    state_e          state_q, state_d;
    logic [BCDW-1:0] bcd_q, bcd_d;
    logic [BINW-1:0] bin_q, bin_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            err_pend_q, err_pend_d;

    // Digit 0 is the ones digit; digits above hundreds read as zero.
    for (genvar g = 0; g < NDIG; g++) begin : g_in
        if (g == 0) begin : g_ones
            assign bcd_in[BCD_DIGIT_W*g +: BCD_DIGIT_W] = bcdOnes;
        end else if (g == 1) begin : g_tens
            assign bcd_in[BCD_DIGIT_W*g +: BCD_DIGIT_W] = bcdTens;
        end else if (g == 2) begin : g_hund
            assign bcd_in[BCD_DIGIT_W*g +: BCD_DIGIT_W] = bcdHundreds;
        end else begin : g_zero
            assign bcd_in[BCD_DIGIT_W*g +: BCD_DIGIT_W] = '0;
        end
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_invalid(bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                in_bad = 1'b1;
            end
        end
    end

    assign shifted = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (shifted[BINW + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_pend_d = err_pend_q;
        case (state_q)
            IDLE: begin
                // A rejected request spends one cycle here before DONE so its latency is one cycle.
                if (err_pend_q) begin
                    err_pend_d = 1'b0;
                    state_d    = DONE;
                end else if (start) begin
                    bin_d = '0;
                    cnt_d = '0;
                    if (in_bad) begin
                        err_d      = 1'b1;
                        bcd_d      = '0;
                        err_pend_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        bcd_d   = bcd_in;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = shifted[BINW-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign bin       = bin_q;
    assign state_dbg = state_q;

endmodule
